// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: PC/instruction widths, fetch-queue state encoding and queue entry layout.
package cpu_pkg;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fq_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding packed {pc, instr} fetch entries; flush clears pointers and count
// and takes priority over push/pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DATA_W = $bits(fetch_entry_t),
    parameter int DEPTH  = 4
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [DATA_W-1:0]          i_data,
    output logic [DATA_W-1:0]          o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Callers should already gate these; guard anyway so the count can never over/underflow.
    assign w_push = i_push && !o_full && !i_flush;
    assign w_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_q.sv
// Fetch stage: drives the instruction ROM address, queues {pc, mach_code} for decode, redirects on
// taken branches and halts at DONE_PC. Define FETCHQ_STATS_EN to add the bubble_cnt stall counter.
module instr_fetch_q
    import cpu_pkg::*;
#(
    parameter int D       = 12,
    parameter int W       = 9,
    parameter int DEPTH   = 4,
    parameter int DONE_PC = 400
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [D-1:0] rom_addr,
    input  logic [W-1:0] rom_data,
    input  logic         jump_en,
    input  logic [D-1:0] jump_target,
    output logic         deq_valid,
    input  logic         deq_ready,
    output logic [W-1:0] deq_instr,
    output logic [D-1:0] deq_pc,
    output logic         halted
`ifdef FETCHQ_STATS_EN
   ,output logic [15:0]  bubble_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH+1);
    // A DONE_PC beyond the PC range can never match, so fetch simply wraps.
    localparam bit            DONE_REACHABLE = (DONE_PC < (1 << D));
    localparam logic [D-1:0]  DONE_PC_V      = D'(DONE_PC);

    fq_state_t        r_state;
    fq_state_t        w_state_nxt;
    logic [D-1:0]     r_fetch_pc;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_run;
    logic             w_at_done;
    logic             w_pop;
    logic             w_push;
    logic             w_jump;
    logic             w_flush;
    logic [D+W-1:0]   w_wr_data;
    logic [D+W-1:0]   w_rd_data;

    assign w_run     = (r_state == RUN);
    assign w_at_done = DONE_REACHABLE && (r_fetch_pc == DONE_PC_V);
    assign deq_valid = (w_count != '0);
    assign w_pop     = deq_valid && deq_ready;
    assign w_jump    = w_run && jump_en && w_pop && !start;
    assign w_flush   = start || w_jump;
    // Push looks only at the registered count: a full queue does not refill in the cycle it pops.
    assign w_push    = w_run && !w_at_done && !w_full && !w_flush;

    assign w_wr_data = {r_fetch_pc, rom_data};
    assign deq_pc    = w_rd_data[D+W-1:W];
    assign deq_instr = w_rd_data[W-1:0];
    assign rom_addr  = r_fetch_pc;
    assign halted    = (r_state == HALT);

    fetch_fifo #(
        .DATA_W (D+W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (w_wr_data),
        .o_data  (w_rd_data),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start) w_state_nxt = RUN;
            RUN: begin
                if (start) begin
                    w_state_nxt = RUN;
                end else if (w_at_done && w_empty) begin
                    w_state_nxt = HALT;
                end
            end
            HALT: if (start) w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= '0;
        end else if (start) begin
            r_fetch_pc <= '0;
        end else if (w_jump) begin
            r_fetch_pc <= jump_target;
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + D'(1);
        end
    end

`ifdef FETCHQ_STATS_EN
    logic [15:0] r_bubble_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bubble_cnt <= '0;
        end else if (start) begin
            r_bubble_cnt <= '0;
        end else if (w_run && deq_ready && !deq_valid && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_q.sv
// Directed bench for instr_fetch_q: default instance (DONE_PC=400) plus a DONE_PC=8 instance.
module tb_instr_fetch_q;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        jump_en;
    logic [11:0] jump_target;
    logic        deq_ready;
    logic [11:0] rom_addr;
    logic [8:0]  rom_data;
    logic        deq_valid;
    logic [8:0]  deq_instr;
    logic [11:0] deq_pc;
    logic        halted;

    logic        start_b;
    logic        ready_b;
    logic [11:0] rom_addr_b;
    logic [8:0]  rom_data_b;
    logic        deq_valid_b;
    logic [8:0]  deq_instr_b;
    logic [11:0] deq_pc_b;
    logic        halted_b;

`ifdef FETCHQ_STATS_EN
    logic [15:0] bubble_cnt;
    logic [15:0] bubble_cnt_b;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign rom_data   = rom_addr[8:0];
    assign rom_data_b = rom_addr_b[8:0];

    instr_fetch_q u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .deq_valid   (deq_valid),
        .deq_ready   (deq_ready),
        .deq_instr   (deq_instr),
        .deq_pc      (deq_pc),
        .halted      (halted)
`ifdef FETCHQ_STATS_EN
       ,.bubble_cnt  (bubble_cnt)
`endif
    );

    instr_fetch_q #(.DONE_PC(8)) u_dut8 (
        .clk         (clk),
        .reset       (reset),
        .start       (start_b),
        .rom_addr    (rom_addr_b),
        .rom_data    (rom_data_b),
        .jump_en     (1'b0),
        .jump_target (12'd0),
        .deq_valid   (deq_valid_b),
        .deq_ready   (ready_b),
        .deq_instr   (deq_instr_b),
        .deq_pc      (deq_pc_b),
        .halted      (halted_b)
`ifdef FETCHQ_STATS_EN
       ,.bubble_cnt  (bubble_cnt_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        jump_en     = 1'b0;
        jump_target = '0;
        deq_ready   = 1'b0;
        start_b     = 1'b0;
        ready_b     = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", deq_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_valid_b", deq_valid_b, 0);
        reset = 1'b1;

        // Streaming with deq_ready held high
        @(negedge clk);
        check("idle_valid", deq_valid, 0);
        check("idle_rom_addr", rom_addr, 0);
        start     = 1'b1;
        deq_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t1_lat_valid", deq_valid, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t1_valid", deq_valid, 1);
            check("t1_pc", deq_pc, i);
            check("t1_instr", deq_instr, i);
            check("t1_rom_addr", rom_addr, i + 1);
        end

        // Restart with stalled decode: queue fills to DEPTH then drains gap-free
        start     = 1'b1;
        deq_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("t2_flush_valid", deq_valid, 0);
        check("t2_flush_rom_addr", rom_addr, 0);
        repeat (5) @(negedge clk);
        check("t2_full_rom_addr", rom_addr, 4);
        check("t2_full_valid", deq_valid, 1);
        deq_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            check("t2_valid", deq_valid, 1);
            check("t2_pc", deq_pc, j);
            if (j != 5) @(negedge clk);
        end

        // Taken jump on head PC 5 while 6,7 are queued
        check("t3_pre_rom_addr", rom_addr, 8);
`ifdef FETCHQ_STATS_EN
        check("t6_bubble_pre", bubble_cnt, 0);
`endif
        jump_en     = 1'b1;
        jump_target = 12'd100;
        @(negedge clk);
        jump_en = 1'b0;
        check("t3_flush_valid", deq_valid, 0);
        check("t3_rom_addr", rom_addr, 100);
        @(negedge clk);
        check("t3_tgt_valid", deq_valid, 1);
        check("t3_tgt_pc", deq_pc, 100);
        check("t3_tgt_instr", deq_instr, 100);
`ifdef FETCHQ_STATS_EN
        check("t6_bubble_jump", bubble_cnt, 1);
`endif
        @(negedge clk);
        check("t3_pc_101", deq_pc, 101);
        check("t3_rom_addr_102", rom_addr, 102);
        @(negedge clk);
        check("t3_pc_102", deq_pc, 102);
`ifdef FETCHQ_STATS_EN
        check("t6_bubble_hold", bubble_cnt, 1);
`endif

        // Start during RUN discards entries and clears stats
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rs_valid", deq_valid, 0);
        check("rs_rom_addr", rom_addr, 0);
`ifdef FETCHQ_STATS_EN
        check("t6_bubble_clear", bubble_cnt, 0);
`endif
        @(negedge clk);
        check("rs_head_valid", deq_valid, 1);
        check("rs_head_pc", deq_pc, 0);

        // Asynchronous reset with three entries queued
        deq_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_pre_pc", deq_pc, 0);
        check("t5_pre_rom_addr", rom_addr, 3);
        #2 reset = 1'b0;
        #1;
        check("t5_async_valid", deq_valid, 0);
        check("t5_async_halted", halted, 0);
        check("t5_async_rom_addr", rom_addr, 0);
        @(negedge clk);
        reset     = 1'b1;
        deq_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_post_valid", deq_valid, 0);
        check("t5_post_rom_addr", rom_addr, 0);
        check("t5_post_halted", halted, 0);
`ifdef FETCHQ_STATS_EN
        check("t5_post_bubble", bubble_cnt, 0);
`endif

        // Program end at DONE_PC=8
        ready_b = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("t4_lat_valid", deq_valid_b, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t4_valid", deq_valid_b, 1);
            check("t4_pc", deq_pc_b, k);
        end
        check("t4_last_rom_addr", rom_addr_b, 8);
        check("t4_last_halted", halted_b, 0);
        @(negedge clk);
        check("t4_drain_valid", deq_valid_b, 0);
        check("t4_drain_halted", halted_b, 0);
        check("t4_drain_rom_addr", rom_addr_b, 8);
        @(negedge clk);
        check("t4_halted", halted_b, 1);
        check("t4_halt_rom_addr", rom_addr_b, 8);
        repeat (2) @(negedge clk);
        check("t4_hold_halted", halted_b, 1);
        check("t4_hold_rom_addr", rom_addr_b, 8);
        check("t4_hold_valid", deq_valid_b, 0);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("t4_restart_halted", halted_b, 0);
        check("t4_restart_rom_addr", rom_addr_b, 0);
        @(negedge clk);
        check("t4_restart_valid", deq_valid_b, 1);
        check("t4_restart_pc", deq_pc_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
